// File: rtl/ripple_sampler_if.sv
// rtl/ripple_sampler_if.sv - event handshake bundle between ripple_sampler and its consumer
//
// Signals:
//   evt_valid  producer -> consumer  event available
//   evt_ready  consumer -> producer  consumer accepts event
//   evt_delta  producer -> consumer  ticks represented by this event (ACC_W)
//   evt_total  producer -> consumer  running total at time of event (ACC_W)
// Modports: master (ripple_sampler side), slave (consumer side).
interface ripple_sampler_if #(
  parameter int ACC_W = 16
);
  logic             evt_valid;
  logic             evt_ready;
  logic [ACC_W-1:0] evt_delta;
  logic [ACC_W-1:0] evt_total;

  modport master (output evt_valid, output evt_delta, output evt_total, input evt_ready);
  modport slave  (input evt_valid, input evt_delta, input evt_total, output evt_ready);
endinterface

// File: rtl/ripple_sampler.sv
// rtl/ripple_sampler.sv - filtered sampler of an asynchronous ripple counter with delta/total events
//
// Ports:
//   clk         in   system clock, rising edge
//   rstn        in   synchronous active-low reset
//   cnt_in      in   asynchronous ripple counter code (WIDTH)
//   clr         in   synchronous clear of total/pending/event/overflow
//   evt         master modport of ripple_sampler_if (evt_valid/evt_ready/evt_delta/evt_total)
//   overflow    out  sticky: total wrapped or pending delta saturated
//   glitch_cnt  out  abandoned-candidate counter, present only with RIPPLE_SAMPLER_GLITCH_CNT_EN
//
// Optional feature macro: RIPPLE_SAMPLER_GLITCH_CNT_EN
module ripple_sampler #(
  parameter int WIDTH  = 4,
  parameter int STABLE = 3,
  parameter int ACC_W  = 16,
  parameter int DOWN   = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [WIDTH-1:0]  cnt_in,
  input  logic              clr,
  ripple_sampler_if.master  evt,
  output logic              overflow
`ifdef RIPPLE_SAMPLER_GLITCH_CNT_EN
  ,
  output logic [7:0]        glitch_cnt
`endif
);

  localparam int SW = $clog2(STABLE + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE);
  localparam logic [SW-1:0] STAB_PRE = SW'(STABLE - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] s1, s2, cand, last;
  logic [SW-1:0]    stab_cnt;
  logic [ACC_W-1:0] total, pend;
  logic             evt_valid_q;
  logic [ACC_W-1:0] evt_delta_q, evt_total_q;

  logic             accept, change, hs;
  logic [WIDTH-1:0] step_w;
  logic [ACC_W-1:0] step_d, d_eff;
  logic [ACC_W:0]   tot_sum, pend_sum;

  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    // MSB flags saturation; the value itself pins at all-ones
    if (s[ACC_W]) s = {1'b1, {ACC_W{1'b1}}};
    return s;
  endfunction

  // The edge where stab_cnt would reach STABLE is the accept edge
  assign accept   = (s2 == cand) && (stab_cnt == STAB_PRE);
  assign change   = accept && (state == RUN) && (cand != last);
  assign step_w   = (DOWN != 0) ? (last - cand) : (cand - last);
  assign step_d   = ACC_W'(step_w);
  assign d_eff    = change ? step_d : '0;
  assign tot_sum  = {1'b0, total} + {1'b0, step_d};
  assign pend_sum = sat_add(pend, d_eff);
  assign hs       = evt_valid_q && evt.evt_ready;

  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_delta = evt_delta_q;
  assign evt.evt_total = evt_total_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1          <= '0;
      s2          <= '0;
      cand        <= '0;
      last        <= '0;
      stab_cnt    <= '0;
      state       <= INIT;
      total       <= '0;
      pend        <= '0;
      evt_valid_q <= 1'b0;
      evt_delta_q <= '0;
      evt_total_q <= '0;
      overflow    <= 1'b0;
    end else begin
      s1 <= cnt_in;
      s2 <= s1;

      if (s2 != cand) begin
        cand     <= s2;
        stab_cnt <= SW'(1);
      end else if (stab_cnt < STAB_MAX) begin
        stab_cnt <= stab_cnt + 1'b1;
      end

      if (clr) begin
        // accept on this edge is dropped entirely: last/state keep their values
        total       <= '0;
        pend        <= '0;
        evt_valid_q <= 1'b0;
        overflow    <= 1'b0;
      end else begin
        if (accept && state == INIT) begin
          last  <= cand;
          state <= RUN;
        end

        if (change) begin
          last  <= cand;
          total <= tot_sum[ACC_W-1:0];
          if (tot_sum[ACC_W]) overflow <= 1'b1;
        end

        if (!evt_valid_q) begin
          if (change) begin
            evt_delta_q <= step_d;
            evt_total_q <= tot_sum[ACC_W-1:0];
            evt_valid_q <= 1'b1;
          end
        end else if (!hs) begin
          // presented event frozen; fold new ticks into pend
          if (change) begin
            pend <= pend_sum[ACC_W-1:0];
            if (pend_sum[ACC_W]) overflow <= 1'b1;
          end
        end else if (change || pend != '0) begin
          evt_delta_q <= pend_sum[ACC_W-1:0];
          evt_total_q <= change ? tot_sum[ACC_W-1:0] : total;
          pend        <= '0;
          if (pend_sum[ACC_W]) overflow <= 1'b1;
        end else begin
          evt_valid_q <= 1'b0;
        end
      end
    end
  end

`ifdef RIPPLE_SAMPLER_GLITCH_CNT_EN
  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      glitch_cnt <= '0;
    end else if ((s2 != cand) && (stab_cnt != '0) && (stab_cnt < STAB_MAX) && (glitch_cnt != 8'hFF)) begin
      glitch_cnt <= glitch_cnt + 8'd1;
    end
  end
`endif

endmodule
